// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback with a memory ready handshake.
// Optional build macro MIPS_MC_CTRL_PERF_EN adds perf_cycles/perf_instrs counters.
module mips_mc_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_en,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal_instr,
  output logic [STW-1:0] dbg_state
`ifdef MIPS_MC_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_instrs
`endif
);

  typedef enum logic [STW-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  state_t state_r;
  state_t state_nxt;

  // funct is decoded by the ALU control, not here
  logic unused_funct;
  assign unused_funct = ^funct;

  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt;
  end

  assign dbg_state = state_r;

  always_comb begin
    state_nxt     = S_FETCH;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;

    case (state_r)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_nxt = S_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_ADDI:       state_nxt = S_ADDIEX;
          OP_J:          state_nxt = S_JUMP;
          default:       state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset aborts whatever is in flight: no strobes leave the block this cycle
    if (rst) begin
      state_nxt     = S_FETCH;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_en         = 1'b0;
      pc_src        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

`ifdef MIPS_MC_CTRL_PERF_EN
  // An instruction retires on every return to FETCH, illegal ones included
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= 32'd0;
      perf_instrs <= 32'd0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (state_r != S_FETCH && state_nxt == S_FETCH)
        perf_instrs <= perf_instrs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus pushes per-cycle expectations from an
// instruction-plan reference model; a negedge monitor pops and compares.
module tb_mips_mc_ctrl;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXEC = 6, P_RWB = 7, P_BRANCH = 8, P_ADDIEX = 9,
                 P_ADDIWB = 10, P_JUMP = 11, P_ILLEGAL = 12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_en, alu_src_a;
  logic       reg_write, reg_dst, mem_to_reg, illegal_instr;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] dbg_state;
`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .dbg_state(dbg_state)
`ifdef MIPS_MC_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_instrs(perf_instrs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] sig;
    int          cyc;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] pcyc;
    logic [31:0] pins;
`endif
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: current phase plus the remaining phases of this instruction
  int          phase = P_FETCH;
  int          plan[$];
  int          cyc_no = 0;
  logic [31:0] m_cycles = 0;
  logic [31:0] m_instrs = 0;
  logic [5:0]  cur_op = 6'd0;

  function automatic logic [19:0] expect_sig(int p, logic r, logic mr, logic z);
    logic mreq, mwe, io, irw, pce, asa, rw, rd, m2r, ill;
    logic [1:0] psrc, asb, aop;
    {mreq, mwe, io, irw, pce, asa, rw, rd, m2r, ill} = '0;
    psrc = 2'b00; asb = 2'b00; aop = 2'b00;
    if (!r) begin
      case (p)
        P_FETCH:   begin mreq = 1; asb = 2'b01; irw = mr; pce = mr; end
        P_DECODE:  asb = 2'b11;
        P_MEMADR:  begin asa = 1; asb = 2'b10; end
        P_MEMRD:   begin mreq = 1; io = 1; end
        P_MEMWB:   begin rw = 1; m2r = 1; end
        P_MEMWR:   begin mreq = 1; mwe = 1; io = 1; end
        P_EXEC:    begin asa = 1; aop = 2'b10; end
        P_RWB:     begin rw = 1; rd = 1; end
        P_BRANCH:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pce = z; end
        P_ADDIEX:  begin asa = 1; asb = 2'b10; end
        P_ADDIWB:  rw = 1;
        P_JUMP:    begin psrc = 2'b10; pce = 1; end
        P_ILLEGAL: ill = 1;
        default:   ;
      endcase
    end
    return {4'(p), mreq, mwe, io, irw, pce, psrc, asa, asb, aop, rw, rd, m2r, ill};
  endfunction

  // Phases an instruction walks through after DECODE
  function automatic void build_plan(logic [5:0] op);
    plan.delete();
    case (op)
      OP_R:    begin plan.push_back(P_EXEC); plan.push_back(P_RWB); end
      OP_LW:   begin plan.push_back(P_MEMADR); plan.push_back(P_MEMRD); plan.push_back(P_MEMWB); end
      OP_SW:   begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWR); end
      OP_BEQ:  plan.push_back(P_BRANCH);
      OP_ADDI: begin plan.push_back(P_ADDIEX); plan.push_back(P_ADDIWB); end
      OP_J:    plan.push_back(P_JUMP);
      default: plan.push_back(P_ILLEGAL);
    endcase
  endfunction

  function automatic int next_of_plan();
    if (plan.size() == 0) return P_FETCH;
    return plan.pop_front();
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic z);
    exp_t e;
    int   nxt;
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = mr; zero = z; funct = 6'($urandom());
    e.sig = expect_sig(phase, r, mr, z);
    e.cyc = cyc_no;
`ifdef MIPS_MC_CTRL_PERF_EN
    e.pcyc = m_cycles;
    e.pins = m_instrs;
`endif
    exp_q.push_back(e);
    cyc_no++;
    if (r) begin
      nxt = P_FETCH;
      plan.delete();
    end else begin
      case (phase)
        P_FETCH:  nxt = mr ? P_DECODE : P_FETCH;
        P_DECODE: begin build_plan(op); nxt = next_of_plan(); end
        P_MEMRD, P_MEMWR: nxt = mr ? next_of_plan() : phase;
        default:  nxt = next_of_plan();
      endcase
    end
    if (r) begin
      m_cycles = 0;
      m_instrs = 0;
    end else begin
      m_cycles = m_cycles + 1;
      if (phase != P_FETCH && nxt == P_FETCH) m_instrs = m_instrs + 1;
    end
    phase = nxt;
  endtask

  task automatic run(input logic [5:0] op, input int n, input logic z);
    for (int i = 0; i < n; i++) step(1'b0, op, 1'b1, z);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] r;
    r = 6'($urandom());
    case ($urandom_range(0, 7))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      default: return r;
    endcase
  endfunction

  // Monitor: the DUT presents a control vector every cycle
  initial begin
    exp_t       e;
    logic [19:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {dbg_state, mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_instr};
        checks++;
        if (act !== e.sig) begin
          failures++;
          $display("FAIL ctrl_vec cycle=%0d actual=%05h required=%05h", e.cyc, act, e.sig);
        end
`ifdef MIPS_MC_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== e.pcyc) begin
          failures++;
          $display("FAIL perf_cycles cycle=%0d actual=%0d required=%0d", e.cyc, perf_cycles, e.pcyc);
        end
        checks++;
        if (perf_instrs !== e.pins) begin
          failures++;
          $display("FAIL perf_instrs cycle=%0d actual=%0d required=%0d", e.cyc, perf_instrs, e.pins);
        end
`endif
      end
    end
  end

  initial begin
    logic mr, r;
    // Reset for two cycles with random opcodes
    step(1'b1, rand_op(), 1'b1, 1'b1);
    step(1'b1, rand_op(), 1'b1, 1'b0);
    // R-type back to back
    run(OP_R, 8, 1'b0);
    // lw with fetch and read waits
    step(1'b0, OP_LW, 1'b0, 1'b0);
    step(1'b0, OP_LW, 1'b0, 1'b0);
    step(1'b0, OP_LW, 1'b1, 1'b0);
    step(1'b0, OP_LW, 1'b1, 1'b0);
    step(1'b0, OP_LW, 1'b1, 1'b0);
    step(1'b0, OP_LW, 1'b0, 1'b0);
    step(1'b0, OP_LW, 1'b0, 1'b0);
    step(1'b0, OP_LW, 1'b0, 1'b0);
    step(1'b0, OP_LW, 1'b1, 1'b0);
    step(1'b0, OP_LW, 1'b1, 1'b0);
    // beq taken then not taken, illegal, jump
    run(OP_BEQ, 3, 1'b1);
    run(OP_BEQ, 3, 1'b0);
    run(OP_BAD, 3, 1'b0);
    run(OP_J, 3, 1'b0);
    // sw stalled in MEMWR, then reset mid-wait with ready high
    run(OP_SW, 3, 1'b0);
    step(1'b0, OP_SW, 1'b0, 1'b0);
    step(1'b0, OP_SW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b1, 1'b0);
    // one full addi, then the first cycle of the following fetch
    run(OP_ADDI, 5, 1'b0);
    // Randomised traffic with occasional resets and memory stalls
    for (int i = 0; i < 600; i++) begin
      if (phase == P_FETCH) cur_op = rand_op();
      mr = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 49) == 0);
      step(r, cur_op, mr, 1'($urandom()));
    end
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle combinational control with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives PC, IR, register-file, ALU-mux and memory enables. It waits on a memory ready handshake so that instruction and data memories can have variable latency.

Parameters:
OPW, 6, opcode/funct field width
STW, 4, state encoding width (dbg_state)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26] from instruction register
funct  in  6  IR[5:0]; not decoded here, passed on via alu_op=10
zero  in  1  ALU zero flag (current cycle)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a write
iord  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_en  out  1  PC load enable
pc_src  out  2  00=ALU result, 01=ALUOut reg, 10=jump target
alu_src_a  out  1  0=PC, 1=A reg
alu_src_b  out  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op  out  2  00=add, 01=sub, 10=use funct
reg_write  out  1  register-file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal_instr  out  1  one-cycle pulse on an undecodable opcode
dbg_state  out  4  current state encoding

Behaviour:
- Single clock; reset is synchronous and active-high on rst. While rst=1: next state=FETCH, and every output except dbg_state is 0. After release, the first FETCH begins on the next edge.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12. Codes 13-15 are unreachable and go to FETCH with all outputs 0.
- FETCH
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en = mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: 000000→EXEC, 100011/101011→MEMADR, 000100→BRANCH, 001000→ADDIEX, 000010→JUMP, other→ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1. Goes to FETCH.
- ILLEGAL: illegal_instr=1 for exactly one cycle. Goes to FETCH; the instruction is skipped because the PC was already advanced in FETCH.
- Latency (mem_ready tied to 1): R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3, illegal 3.
- Outputs not listed for a state are 0. All outputs are a pure decode of state, except the pc_en/ir_write gating by mem_ready and zero.
- mem_ready=1 outside FETCH/MEMRD/MEMWR is ignored.
- mem_req stays high continuously during a wait. mem_we and iord are stable for the whole wait.
- rst asserted mid-instruction, including during a memory wait, aborts the instruction. The FSM returns to FETCH with no write strobes in the reset cycle.

Optional Feature:
- Macro: MIPS_MC_CTRL_PERF_EN.
- When defined, adds outputs perf_cycles[31:0] and perf_instrs[31:0], both cleared by rst.
  - perf_cycles increments every non-reset cycle.
  - perf_instrs increments on every transition into FETCH from a non-FETCH state, ILLEGAL included.
  - Both wrap from 0xFFFFFFFF to 0.
- When not defined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random opcode → all outputs 0. After release, dbg_state=0, mem_req=1, pc_en=1 (mem_ready=1).
- R-type: opcode=000000, mem_ready=1 → dbg_state sequence 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7; 4 cycles per instruction.
- lw with waits: opcode=100011, mem_ready low 2 cycles in FETCH and 3 in MEMRD → ir_write/pc_en pulse once on the ready cycle. States 0,0,0,1,2,3,3,3,3,4,0, with mem_we=0 throughout.
- beq: opcode=000100 run with zero=1 and with zero=0 → pc_en=1/pc_src=01 in BRANCH only when zero=1. 3 cycles either way.
- Illegal/jump: opcode=111111 → illegal_instr is a single-cycle pulse, then FETCH. opcode=000010 → pc_en=1 with pc_src=10 in JUMP.
- Reset mid-op: assert rst during MEMWR wait (mem_req=1, mem_we=1) → mem_we=0 in the reset cycle, FETCH afterwards. With MIPS_MC_CTRL_PERF_EN, counters read 0 after reset and perf_instrs=1 after one complete addi.
